// File: rtl/bcd_scan_display_pkg.sv
// ----------------------------------------------------------------------------
// bcd_disp_pkg
// Shared types and constants for the BCD scan display block.
//   state_e   : scan FSM states (IDLE, BLANK, SHOW)
//   SEG_BLANK : active-low segment pattern with every segment dark
//   seg_lut() : 16-entry BCD to active-low {g,f,e,d,c,b,a} lookup.
//               Codes 10..15 (including the 4'hF blank code) map to SEG_BLANK.
// ----------------------------------------------------------------------------
package bcd_disp_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BLANK = 2'd1,
      SHOW  = 2'd2
   } state_e;

   localparam logic [6:0] SEG_BLANK = 7'h7F;

   function automatic logic [6:0] seg_lut(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'h40;
         4'd1:    s = 7'h79;
         4'd2:    s = 7'h24;
         4'd3:    s = 7'h30;
         4'd4:    s = 7'h19;
         4'd5:    s = 7'h12;
         4'd6:    s = 7'h02;
         4'd7:    s = 7'h78;
         4'd8:    s = 7'h00;
         4'd9:    s = 7'h10;
         default: s = SEG_BLANK;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/bcd_scan_display_if.sv
// ----------------------------------------------------------------------------
// bcd_scan_display_if
// Muxed digit read bus between the scan display (master) and the 8-digit
// BCD counter bank (slave).
//   sel   : digit index requested by the scanner
//   en    : read enable toward the counter bank
//   digit : BCD digit returned for the current sel (4'hF = blank)
// ----------------------------------------------------------------------------
interface bcd_scan_display_if;
   logic [2:0] sel;
   logic       en;
   logic [3:0] digit;

   modport master (output sel, output en, input digit);
   modport slave  (input sel, input en, output digit);
endinterface

// File: rtl/bcd_scan_display_seg.sv
// ----------------------------------------------------------------------------
// bcd_to_seg
// Purely combinational BCD to active-low 7-segment decoder.
//   digit_i : 4-bit BCD code (10..15 decode to all segments off)
//   seg_o   : segments {g,f,e,d,c,b,a}, active-low
// ----------------------------------------------------------------------------
module bcd_to_seg
   import bcd_disp_pkg::*;
(
   input  logic [3:0] digit_i,
   output logic [6:0] seg_o
);

   assign seg_o = seg_lut(digit_i);

endmodule

// File: rtl/bcd_scan_display.sv
// ----------------------------------------------------------------------------
// bcd_scan_display
// Time-multiplexes the 8 digits of the BCD counter bank onto a common-anode
// 7-segment display. Each slot is SLOT_CYC cycles: BLANK_CYC cycles with all
// anodes off while the new digit settles, then the digit is shown.
//
// Ports:
//   clk       : system clock
//   rst       : asynchronous active-high reset
//   disp_on_i : display enable, 0 forces IDLE
//   bus       : counter bank read bus (master side: sel/en out, digit in)
//   seg_o     : segments {g,f,e,d,c,b,a}, active-low
//   dp_o      : decimal point, active-low
//   an_o      : digit anodes, active-low, at most one low
//
// Optional feature: define BCD_SCAN_LZ_BLANK_EN for leading-zero suppression
// (index 0 is most significant, index 7 is never suppressed).
// ----------------------------------------------------------------------------
module bcd_scan_display
   import bcd_disp_pkg::*;
#(
   parameter int          SLOT_CYC  = 50000,
   parameter int          BLANK_CYC = 2,
   parameter logic [7:0]  DP_MASK   = 8'b0010_1000
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       disp_on_i,
   bcd_scan_display_if.master         bus,
   output logic [6:0]                 seg_o,
   output logic                       dp_o,
   output logic [7:0]                 an_o
);

   localparam int                CNT_W      = $clog2(SLOT_CYC);
   localparam logic [CNT_W-1:0]  BLANK_LAST = CNT_W'(BLANK_CYC - 1);
   localparam logic [CNT_W-1:0]  SLOT_LAST  = CNT_W'(SLOT_CYC - 1);

   state_e            state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [2:0]        sel_q;
   logic              en_q;
   logic [7:0]        an_q;
   logic              dp_q;
   logic [3:0]        digit_q;   // captured digit; held at 4'hF outside SHOW
   logic [3:0]        cap_d;     // value latched into digit_q at end of BLANK
   logic [7:0]        an_sel;    // anode pattern lighting position sel_q

`ifdef BCD_SCAN_LZ_BLANK_EN
   logic              nz_seen_q; // a nonzero digit has been captured this frame
`endif

   // One-low anode pattern for the current index.
   for (genvar gi = 0; gi < 8; gi++) begin : g_an
      assign an_sel[gi] = (sel_q != 3'(gi));
   end

   always_comb begin
      cap_d = bus.digit;
`ifdef BCD_SCAN_LZ_BLANK_EN
      // Zero with only zeros before it in this frame is a leading zero.
      if (bus.digit == 4'd0 && !nz_seen_q && sel_q != 3'd7) begin
         cap_d = 4'hF;
      end
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         sel_q     <= 3'd0;
         en_q      <= 1'b0;
         an_q      <= 8'hFF;
         dp_q      <= 1'b1;
         digit_q   <= 4'hF;
`ifdef BCD_SCAN_LZ_BLANK_EN
         nz_seen_q <= 1'b0;
`endif
      end else if (!disp_on_i) begin
         // Dropping the enable always abandons the slot and rewinds to index 0.
         state_q   <= IDLE;
         cnt_q     <= '0;
         sel_q     <= 3'd0;
         en_q      <= 1'b0;
         an_q      <= 8'hFF;
         dp_q      <= 1'b1;
         digit_q   <= 4'hF;
`ifdef BCD_SCAN_LZ_BLANK_EN
         nz_seen_q <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               state_q   <= BLANK;
               cnt_q     <= '0;
               sel_q     <= 3'd0;
               en_q      <= 1'b1;
               an_q      <= 8'hFF;
               dp_q      <= 1'b1;
               digit_q   <= 4'hF;
`ifdef BCD_SCAN_LZ_BLANK_EN
               nz_seen_q <= 1'b0;
`endif
            end

            BLANK: begin
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == BLANK_LAST) begin
                  // digit has had BLANK_CYC cycles to settle after sel moved.
                  state_q <= SHOW;
                  digit_q <= cap_d;
                  an_q    <= an_sel;
                  dp_q    <= ~DP_MASK[sel_q];
`ifdef BCD_SCAN_LZ_BLANK_EN
                  if (bus.digit != 4'd0) begin
                     nz_seen_q <= 1'b1;
                  end
`endif
               end
            end

            SHOW: begin
               if (cnt_q == SLOT_LAST) begin
                  state_q <= BLANK;
                  cnt_q   <= '0;
                  sel_q   <= sel_q + 3'd1;
                  an_q    <= 8'hFF;
                  dp_q    <= 1'b1;
                  digit_q <= 4'hF;
`ifdef BCD_SCAN_LZ_BLANK_EN
                  if (sel_q == 3'd7) begin
                     nz_seen_q <= 1'b0;
                  end
`endif
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end

            default: begin
               state_q <= IDLE;
               cnt_q   <= '0;
               sel_q   <= 3'd0;
               en_q    <= 1'b0;
               an_q    <= 8'hFF;
               dp_q    <= 1'b1;
               digit_q <= 4'hF;
            end
         endcase
      end
   end

   // Decoder sits on the captured register, so seg_o depends only on flops.
   bcd_to_seg u_seg (
      .digit_i (digit_q),
      .seg_o   (seg_o)
   );

   assign bus.sel = sel_q;
   assign bus.en  = en_q;
   assign dp_o    = dp_q;
   assign an_o    = an_q;

endmodule

// File: tb/tb_bcd_scan_display.sv
// ----------------------------------------------------------------------------
// tb_bcd_scan_display
// Directed bench for bcd_scan_display with SLOT_CYC=8, BLANK_CYC=2.
// A combinational table stands in for the counter bank.
// ----------------------------------------------------------------------------
module tb_bcd_scan_display;

   logic       clk;
   logic       rst;
   logic       disp_on;
   logic [6:0] seg;
   logic       dp;
   logic [7:0] an;
   logic [3:0] dig_tbl [8];

   int n_tests = 0;
   int n_fail  = 0;
   int viol    = 0;

   bcd_scan_display_if bus ();

   assign bus.digit = dig_tbl[bus.sel];

   bcd_scan_display #(
      .SLOT_CYC  (8),
      .BLANK_CYC (2),
      .DP_MASK   (8'b0010_1000)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .disp_on_i (disp_on),
      .bus       (bus),
      .seg_o     (seg),
      .dp_o      (dp),
      .an_o      (an)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // At most one anode may ever be low.
   always @(negedge clk) begin
      if (!$onehot0(~an)) viol++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Standard active-low patterns, hand-written.
   function automatic logic [6:0] exp_seg(input int d);
      case (d)
         0: return 7'h40;
         1: return 7'h79;
         2: return 7'h24;
         3: return 7'h30;
         4: return 7'h19;
         5: return 7'h12;
         6: return 7'h02;
         7: return 7'h78;
         8: return 7'h00;
         9: return 7'h10;
         default: return 7'h7F;
      endcase
   endfunction

   function automatic logic exp_dp(input int idx);
      return (idx == 3 || idx == 5) ? 1'b0 : 1'b1;
   endfunction

   // Entered at the negedge of the first BLANK cycle of slot idx; leaves at
   // the negedge of the first BLANK cycle of the following slot.
   task automatic slot_check(input int idx, input logic [6:0] seg_e, input logic dp_e);
      logic [7:0] an_e;
      for (int c = 0; c < 8; c++) begin
         an_e = 8'hFF;
         if (c >= 2) an_e[idx] = 1'b0;
         check("sel", 32'(bus.sel), 32'(idx));
         check("en", 32'(bus.en), 32'd1);
         check("an", 32'(an), 32'(an_e));
         check("seg", 32'(seg), (c >= 2) ? 32'(seg_e) : 32'h7F);
         check("dp", 32'(dp), (c >= 2) ? 32'(dp_e) : 32'd1);
         @(negedge clk);
      end
      $display("[TB] slot idx=%0d seg=%h dp=%b", idx, seg_e, dp_e);
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_an"}, 32'(an), 32'hFF);
      check({tag, "_seg"}, 32'(seg), 32'h7F);
      check({tag, "_dp"}, 32'(dp), 32'd1);
      check({tag, "_en"}, 32'(bus.en), 32'd0);
      check({tag, "_sel"}, 32'(bus.sel), 32'd0);
   endtask

   initial begin
      rst     = 1'b1;
      disp_on = 1'b0;
      for (int i = 0; i < 8; i++) dig_tbl[i] = 4'(i + 2);

      repeat (2) @(negedge clk);
      check_idle("reset");
      rst = 1'b0;
      @(negedge clk);
      check_idle("idle_off");

      // Frame A: digit = sel + 2
      disp_on = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 8; i++) slot_check(i, exp_seg(i + 2), exp_dp(i));

      // Frame B: blank code on index 4, out-of-range code on index 6
      dig_tbl[4] = 4'hF;
      dig_tbl[6] = 4'hA;
      for (int i = 0; i < 8; i++) begin
         slot_check(i, (i == 4 || i == 6) ? 7'h7F : exp_seg(i + 2), exp_dp(i));
      end

      // Frame C: drop disp_on mid-SHOW of index 5
      dig_tbl[4] = 4'd6;
      dig_tbl[6] = 4'd8;
      for (int i = 0; i < 5; i++) slot_check(i, exp_seg(i + 2), exp_dp(i));
      repeat (4) @(negedge clk);
      check("pre_drop_an", 32'(an), 32'hDF);
      disp_on = 1'b0;
      @(negedge clk);
      check_idle("drop");
      @(negedge clk);
      check_idle("drop_hold");
      disp_on = 1'b1;
      @(negedge clk);
      slot_check(0, exp_seg(2), exp_dp(0));

      // Async reset between edges during SHOW of index 1
      repeat (3) @(negedge clk);
      check("pre_rst_an", 32'(an), 32'hFD);
      #2 rst = 1'b1;
      #1 check_idle("async_rst");
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Leading-zero frame
      dig_tbl = '{4'd0, 4'd0, 4'd0, 4'd3, 4'd0, 4'd0, 4'd0, 4'd0};
      for (int i = 0; i < 8; i++) begin
`ifdef BCD_SCAN_LZ_BLANK_EN
         slot_check(i, (i < 3) ? 7'h7F : ((i == 3) ? 7'h30 : 7'h40), exp_dp(i));
`else
         slot_check(i, (i == 3) ? 7'h30 : 7'h40, exp_dp(i));
`endif
      end

      // All-zero frame
      dig_tbl[3] = 4'd0;
      for (int i = 0; i < 8; i++) begin
`ifdef BCD_SCAN_LZ_BLANK_EN
         slot_check(i, (i == 7) ? 7'h40 : 7'h7F, exp_dp(i));
`else
         slot_check(i, 7'h40, exp_dp(i));
`endif
      end

      check("anode_onehot_viol", 32'(viol), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

endmodule
